// File: rtl/crc_net_pkg.sv
// Shared CRC-16/CCITT framing definitions.
// Used by both the serial receiver and transmitter.
package crc_net_pkg;

  localparam int PKT_W = 136;
  localparam int CRC_W = 16;
  localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
  localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // One MSB-first CRC shift of a single serial bit
  function automatic logic [CRC_W-1:0] crc_step(
    input logic [CRC_W-1:0] c,
    input logic             b
  );
    logic fb;
    fb = c[CRC_W-1] ^ b;
    return {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/crc16_serial.sv
// Bit-serial CRC-16/CCITT engine, one bit per bit_en.
// init has priority and reloads the seed value.
module crc16_serial
  import crc_net_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             bit_en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] crc_d;

  // Next CRC: reseed, shift one bit, or hold
  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC_INIT;
    end else if (bit_en) begin
      crc_d = crc_step(crc_q, bit_in);
    end
  end

  // CRC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/rx_receiver.sv
// Serial frame receiver: start, PKT_W data bits MSB first, stop.
// Frame CRC is checked on the fly by crc16_serial.
module rx_receiver #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PKT_W        = crc_net_pkg::PKT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_line,
  output logic [PKT_W-1:0] rx_packet,
  output logic             rx_valid,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             frame_err,
  output logic             rx_busy
);

  import crc_net_pkg::*;

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(PKT_W + 1);

  localparam logic [CNT_W-1:0] CNT_HALF =
    CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST =
    BIT_W'(PKT_W - 1);

  rx_state_e        state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic [2:0]       warm_q, warm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [PKT_W-1:0] shift_q, shift_d;
  logic [PKT_W-1:0] rx_packet_q, rx_packet_d;
  logic             rx_valid_q, rx_valid_d;
  logic             crc_ok_q, crc_ok_d;
  logic             crc_err_q, crc_err_d;
  logic             frame_err_q, frame_err_d;
  logic             rx_busy_q, rx_busy_d;

  logic             crc_init;
  logic             crc_en;
  logic [CRC_W-1:0] crc;
  logic             fall;

  crc16_serial u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (crc_init),
    .bit_en (crc_en),
    .bit_in (sync2_q),
    .crc    (crc)
  );

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d     = state_q;
    sync1_d     = rx_line;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    warm_d      = {warm_q[1:0], 1'b1};
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_packet_d = rx_packet_q;
    rx_valid_d  = 1'b0;
    crc_ok_d    = crc_ok_q;
    crc_err_d   = crc_err_q;
    frame_err_d = 1'b0;
    crc_init    = 1'b0;
    crc_en      = 1'b0;
    // prev_q only holds a real line value once the
    // synchroniser has flushed its reset-time ones
    fall = warm_q[2] & prev_q & ~sync2_q;

    unique case (state_q)
      RX_IDLE: begin
        if (fall) begin
          state_d   = RX_START;
          cnt_d     = '0;
          bit_cnt_d = '0;
          crc_init  = 1'b1;
        end
      end
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          shift_d   = {shift_q[PKT_W-2:0], sync2_q};
          crc_en    = 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = RX_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (sync2_q) begin
            rx_packet_d = shift_q;
            rx_valid_d  = 1'b1;
            crc_ok_d    = (crc == '0);
            crc_err_d   = (crc != '0);
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase

    rx_busy_d = (state_d != RX_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RX_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      warm_q      <= '0;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_packet_q <= '0;
      rx_valid_q  <= 1'b0;
      crc_ok_q    <= 1'b0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      warm_q      <= warm_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_packet_q <= rx_packet_d;
      rx_valid_q  <= rx_valid_d;
      crc_ok_q    <= crc_ok_d;
      crc_err_q   <= crc_err_d;
      frame_err_q <= frame_err_d;
      rx_busy_q   <= rx_busy_d;
    end
  end

  assign rx_packet = rx_packet_q;
  assign rx_valid  = rx_valid_q;
  assign crc_ok    = crc_ok_q;
  assign crc_err   = crc_err_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_rx_receiver.sv
// Directed bench for rx_receiver at 8 clocks per bit.
// Frames are built with a reference CRC-16/CCITT.
module tb_rx_receiver;

  localparam int CPB = 8;
  localparam int PW  = 136;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_line;
  logic [PW-1:0] rx_packet;
  logic          rx_valid;
  logic          crc_ok;
  logic          crc_err;
  logic          frame_err;
  logic          rx_busy;

  int n_pass  = 0;
  int n_total = 0;

  int cyc   = 0;
  int nv    = 0;
  int nf    = 0;
  int nboth = 0;
  int t_last = 0;
  int t_prev = 0;
  logic ok_last = 1'b0;
  logic ok_prev = 1'b0;

  rx_receiver #(
    .CLKS_PER_BIT (CPB),
    .PKT_W        (PW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_line   (rx_line),
    .rx_packet (rx_packet),
    .rx_valid  (rx_valid),
    .crc_ok    (crc_ok),
    .crc_err   (crc_err),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rx_valid) begin
      nv      = nv + 1;
      t_prev  = t_last;
      t_last  = cyc;
      ok_prev = ok_last;
      ok_last = crc_ok;
    end
    if (frame_err) nf = nf + 1;
    if (rx_valid && frame_err) nboth = nboth + 1;
  end

  function automatic logic [15:0] crc_ref(
    input logic [119:0] p
  );
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 119; i >= 0; i--) begin
      fb = c[15] ^ p[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic chk(
    input string         tag,
    input logic [PW-1:0] obs,
    input logic [PW-1:0] exp
  );
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic send_bit(input logic b);
    rx_line = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(
    input logic [PW-1:0] p,
    input logic          stop
  );
    send_bit(1'b0);
    for (int i = PW - 1; i >= 0; i--) send_bit(p[i]);
    send_bit(stop);
  endtask

  logic [119:0]  pay_c;
  logic [119:0]  pay_d;
  logic [PW-1:0] pkt_a;
  logic [PW-1:0] pkt_b;
  logic [PW-1:0] pkt_c;
  logic [PW-1:0] pkt_d;
  logic [PW-1:0] pkt_l;
  logic [PW-1:0] one;
  int v0;
  int f0;
  int busy_n;

  initial begin
    pay_c = 120'h0123456789ABCDEF_FEDCBA98765432;
    pay_d = 120'hA5A5_5A5A_C3C3_3C3C_0F0F_F0F0_1234_56;
    one   = 136'd1;
    pkt_a = {120'h0, crc_ref(120'h0)};
    pkt_b = pkt_a ^ (one << 100);
    pkt_c = {pay_c, crc_ref(pay_c)};
    pkt_d = {pay_d, crc_ref(pay_d)};
    pkt_l = {120'h0, 16'h1D0F};

    rst_n   = 1'b0;
    rx_line = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_packet", rx_packet, '0);
    chk("rst_valid", PW'(rx_valid), '0);
    chk("rst_crc_ok", PW'(crc_ok), '0);
    chk("rst_crc_err", PW'(crc_err), '0);
    chk("rst_frame_err", PW'(frame_err), '0);
    chk("rst_busy", PW'(rx_busy), '0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // good zero-payload frame
    v0 = nv; f0 = nf;
    send_frame(pkt_a, 1'b1);
    repeat (4) @(negedge clk);
    chk("a_valid_cnt", PW'(nv - v0), PW'(1));
    chk("a_ferr_cnt", PW'(nf - f0), '0);
    chk("a_packet", rx_packet, pkt_a);
    chk("a_crc_ok", PW'(crc_ok), PW'(1));
    chk("a_crc_err", PW'(crc_err), '0);

    // zero payload with literal CRC 0x1D0F
    v0 = nv;
    send_frame(pkt_l, 1'b1);
    repeat (4) @(negedge clk);
    chk("l_valid_cnt", PW'(nv - v0), PW'(1));
    chk("l_packet", rx_packet, pkt_l);
    chk("l_crc_ok", PW'(crc_ok),
        PW'(crc_ref(120'h0) == 16'h1D0F));

    // bit 100 flipped
    v0 = nv; f0 = nf;
    send_frame(pkt_b, 1'b1);
    repeat (4) @(negedge clk);
    chk("b_valid_cnt", PW'(nv - v0), PW'(1));
    chk("b_packet", rx_packet, pkt_b);
    chk("b_crc_ok", PW'(crc_ok), '0);
    chk("b_crc_err", PW'(crc_err), PW'(1));

    // 3-clock low glitch
    v0 = nv; f0 = nf;
    busy_n = 0;
    rx_line = 1'b0;
    repeat (3) @(negedge clk);
    rx_line = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rx_busy) busy_n++;
    end
    chk("g_busy_le5",
        PW'(busy_n >= 1 && busy_n <= 5), PW'(1));
    chk("g_busy_end", PW'(rx_busy), '0);
    chk("g_pulses", PW'((nv - v0) + (nf - f0)), '0);

    // stop bit forced low
    v0 = nv; f0 = nf;
    send_frame(pkt_a, 1'b0);
    rx_line = 1'b1;
    repeat (8) @(negedge clk);
    chk("s_ferr_cnt", PW'(nf - f0), PW'(1));
    chk("s_valid_cnt", PW'(nv - v0), '0);
    chk("s_packet", rx_packet, pkt_b);
    chk("s_crc_err", PW'(crc_err), PW'(1));

    // line break
    f0 = nf; v0 = nv;
    rx_line = 1'b0;
    repeat (140 * CPB) @(negedge clk);
    chk("k_ferr_cnt", PW'(nf - f0), PW'(1));
    repeat (300) @(negedge clk);
    chk("k_busy", PW'(rx_busy), '0);
    chk("k_ferr_once", PW'(nf - f0), PW'(1));
    chk("k_valid_cnt", PW'(nv - v0), '0);
    rx_line = 1'b1;
    repeat (16) @(negedge clk);

    // reset during data bit 60
    v0 = nv; f0 = nf;
    send_bit(1'b0);
    for (int i = 0; i < 60; i++) send_bit(pkt_c[PW-1-i]);
    rx_line = pkt_c[PW-61];
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("r_packet_clr", rx_packet, '0);
    chk("r_crc_err_clr", PW'(crc_err), '0);
    rst_n = 1'b1;
    rx_line = 1'b1;
    repeat (20) @(negedge clk);
    chk("r_no_pulse", PW'((nv - v0) + (nf - f0)), '0);
    chk("r_busy", PW'(rx_busy), '0);
    send_frame(pkt_c, 1'b1);
    repeat (4) @(negedge clk);
    chk("r_valid_cnt", PW'(nv - v0), PW'(1));
    chk("r_packet", rx_packet, pkt_c);
    chk("r_crc_ok", PW'(crc_ok), PW'(1));

    // back-to-back frames
    v0 = nv; f0 = nf;
    send_frame(pkt_d, 1'b1);
    send_frame(pkt_c, 1'b1);
    repeat (4) @(negedge clk);
    chk("bb_valid_cnt", PW'(nv - v0), PW'(2));
    chk("bb_spacing", PW'(t_last - t_prev),
        PW'((PW + 2) * CPB));
    chk("bb_ok_first", PW'(ok_prev), PW'(1));
    chk("bb_ok_second", PW'(ok_last), PW'(1));
    chk("bb_packet", rx_packet, pkt_c);
    chk("bb_ferr_cnt", PW'(nf - f0), '0);

    chk("valid_ferr_overlap", PW'(nboth), '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
